alu_checker: RTL
================

# alu_checker

Synthesizable self-checking consumer for the 8-bit ALU result stream. Receives `{a, b, op, result}` tuples over a valid/ready handshake and recomputes the expected result with an internal reference model. It counts passes and failures over a run of `NUM_CHECKS` transactions and latches the first mismatch. It sits at the ALU output as the receiving end of the operand/result stream that the stimulus side produces.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- Parameters:
  - `NUM_CHECKS`, default 24, number of transactions per run; legal range 1..255.
- Ports:
  - `clk` input 1: sole clock, rising edge.
  - `reset_n` input 1: asynchronous active-low reset.
  - `start_i` input 1: single-cycle pulse that begins a run.
  - `valid_i` input 1: a transaction is present.
  - `ready_o` output 1: checker accepts a transaction this cycle.
  - `a_i` input 8: operand A.
  - `b_i` input 8: operand B.
  - `op_i` input 3: ALU opcode.
  - `result_i` input 8: ALU output under test.
  - `busy_o` output 1: run in progress (RUN or DRAIN).
  - `done_o` output 1: run complete, held until next start.
  - `pass_cnt_o` output 8: matching transactions.
  - `fail_cnt_o` output 8: mismatching transactions.
  - `error_o` output 1: sticky; set on any mismatch in the current run.
  - `first_fail_op_o` output 3: opcode of the first mismatch.
  - `first_fail_exp_o` output 8: expected value of the first mismatch.
  - `first_fail_act_o` output 8: actual value of the first mismatch.

## Operation
- Opcode map (all results truncated to 8 bits):
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 SLL: a<<b[2:0]
  - 3 SRL: a>>b[2:0]
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 EQ: 8'h01 if a==b, else 8'h00
- Handshake: a transaction is accepted on a rising edge where `valid_i && ready_o`. `ready_o` is a function of state only (1 in RUN, else 0), never of `valid_i`.
- Pipeline:
  - Stage 1 registers `op`, `result_i` and the model's expected value at acceptance.
  - Stage 2 compares on the following edge and updates the counters and first-fail registers.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start_i` → RUN. On entry to RUN, clear counters, `error_o`, first-fail regs, stage valid, and the accept count.
  - RUN: accept transactions. When the accept count reaches `NUM_CHECKS` on an accept edge → DRAIN.
  - DRAIN: exactly one cycle for the final stage-2 compare, then → DONE.
  - DONE: `done_o`=1. `start_i` → RUN with the same clearing as from IDLE.
- `start_i` is ignored in RUN and DRAIN.
- Counters saturate at 255. `pass_cnt_o + fail_cnt_o == NUM_CHECKS` at DONE.
- First-fail registers load only when `fail_cnt` goes 0→1, and hold thereafter.
- Reset mid-run: immediate return to IDLE. The pipeline valid bit is cleared and the in-flight transaction is discarded.

## Timing
- Reset values:
  - `ready_o` 0
  - `busy_o` 0
  - `done_o` 0
  - `pass_cnt_o` 0
  - `fail_cnt_o` 0
  - `error_o` 0
  - first-fail regs 0
  - state IDLE
- RUN is entered on the edge that samples `start_i`=1. `ready_o` is 1 from the next cycle.
- Counter and `error_o` latency: updated on the edge one cycle after the accept edge.
- With back-to-back accepts, the final count update occurs on the DRAIN→DONE edge. `done_o` rises that same edge, so the counts are final whenever `done_o`=1.
- Throughput: one transaction per cycle while `valid_i` is held.
- `valid_i` gaps in RUN are legal and stall the accept count.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum (the 8 opcodes above)
  - `ALU_W`=8
  - `alu_model(a, b, op)` function returning the expected 8-bit result
  - checker state enum
- Sub-module `alu_ref_model`: combinational wrapper of `alu_model`. It is shared with the ALU's own bench.
- Top `alu_checker`: FSM, handshake, stage registers, counters.

## Test plan
- All-pass sweep:
  - Stimulus: reset; start; feed 24 tuples from a golden ALU (3 passes over ops 0..7, random operands), `valid_i` held high.
  - Required: `done_o`=1 two cycles after the 24th accept; pass=24, fail=0, `error_o`=0.
- Single injected fault:
  - Stimulus: tuple 5 is op=1, a=8'h10, b=8'h20 with `result_i`=8'h00.
  - Required: fail=1, pass=23, `error_o`=1, first-fail op=1, exp=8'hF0, act=8'h00.
- Boundary arithmetic:
  - Stimulus: ADD FF+01, expected 8'h00; SLL 8'h81 by b=8'h09 (shift 1), expected 8'h02; EQ 7F vs 7F, expected 8'h01. All fed with correct results.
  - Required: all pass.
- Stalled stream:
  - Stimulus: `valid_i` toggled every other cycle.
  - Required: exactly 24 accepts, DONE reached, `ready_o` never depends on `valid_i`.
- Restart and ignored start:
  - Stimulus: `start_i` pulsed mid-run; then `start_i` pulsed in DONE.
  - Required: the mid-run pulse has no effect; the pulse in DONE clears all counters to 0 and re-enters RUN.
- Reset mid-run:
  - Stimulus: assert `reset_n`=0 after 10 accepts.
  - Required: asynchronously, all outputs return to their reset values and the state is IDLE; `ready_o` stays 0 until the next start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, data width, golden result function, checker states.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_EQ  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  // Golden ALU behaviour; every result is truncated to ALU_W bits and shifts use b[2:0] only.
  function automatic logic [ALU_W-1:0] alu_model(input logic [ALU_W-1:0] a,
                                                 input logic [ALU_W-1:0] b,
                                                 input logic [2:0]       op);
    logic [ALU_W-1:0] r;
    case (alu_op_t'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << b[2:0];
      OP_SRL:  r = a >> b[2:0];
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_EQ:   r = {{(ALU_W-1){1'b0}}, (a == b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU; shared with the ALU's own bench.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [ALU_W-1:0] exp_o
);

  // Expected result straight from the package golden function.
  always_comb begin
    exp_o = alu_model(a_i, b_i, op_i);
  end

endmodule

// File: rtl/alu_checker.sv
// Self-checking consumer of the ALU result stream: counts pass/fail and latches the first mismatch.
// Latency: counters/error update one edge after the accept edge; done_o rises with the final update.
// Backpressure: ready_o is high only in RUN and never depends on valid_i; gaps stall the accept count.
module alu_checker
  import alu_pkg::*;
#(
  parameter int NUM_CHECKS = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic [ALU_W-1:0] result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       pass_cnt_o,
  output logic [7:0]       fail_cnt_o,
  output logic             error_o,
  output logic [2:0]       first_fail_op_o,
  output logic [ALU_W-1:0] first_fail_exp_o,
  output logic [ALU_W-1:0] first_fail_act_o
);

  // Accept index of the final transaction of a run.
  localparam logic [7:0] LAST_IDX = 8'(NUM_CHECKS - 1);

  chk_state_t       state_q, state_nxt;
  logic             accept;
  logic             run_clr;
  logic [ALU_W-1:0] exp_w;

  logic [7:0]       acc_cnt_q;
  logic             s1_vld_q;
  logic [2:0]       s1_op_q;
  logic [ALU_W-1:0] s1_res_q;
  logic [ALU_W-1:0] s1_exp_q;

  logic [7:0]       pass_cnt_q, fail_cnt_q;
  logic             error_q;
  logic [2:0]       ff_op_q;
  logic [ALU_W-1:0] ff_exp_q, ff_act_q;

  alu_ref_model u_ref_model (
    .a_i   (a_i),
    .b_i   (b_i),
    .op_i  (op_i),
    .exp_o (exp_w)
  );

  assign accept  = valid_i && ready_o;
  // A start is honoured only from IDLE or DONE; it clears all run state on the same edge.
  assign run_clr = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state: leave RUN on the accept that reaches NUM_CHECKS, then one DRAIN cycle.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_nxt = ST_RUN;
      ST_RUN:   if (accept && (acc_cnt_q == LAST_IDX)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (start_i) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_RUN:   begin ready_o = 1'b1; busy_o = 1'b1; end
      ST_DRAIN: busy_o = 1'b1;
      ST_DONE:  done_o = 1'b1;
      default:  ;
    endcase
  end

  // Stage 1: count accepts and capture opcode, DUT result and model expectation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_op_q   <= '0;
      s1_res_q  <= '0;
      s1_exp_q  <= '0;
    end else if (run_clr) begin
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + 8'd1;
        s1_op_q   <= op_i;
        s1_res_q  <= result_i;
        s1_exp_q  <= exp_w;
      end
    end
  end

  // Stage 2: compare, bump saturating counters, latch the first mismatch only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      error_q    <= 1'b0;
      ff_op_q    <= '0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else if (run_clr) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      error_q    <= 1'b0;
      ff_op_q    <= '0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else if (s1_vld_q) begin
      if (s1_res_q == s1_exp_q) begin
        if (pass_cnt_q != 8'hFF) pass_cnt_q <= pass_cnt_q + 8'd1;
      end else begin
        if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
        error_q <= 1'b1;
        if (fail_cnt_q == 8'd0) begin
          ff_op_q  <= s1_op_q;
          ff_exp_q <= s1_exp_q;
          ff_act_q <= s1_res_q;
        end
      end
    end
  end

  assign pass_cnt_o       = pass_cnt_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign error_o          = error_q;
  assign first_fail_op_o  = ff_op_q;
  assign first_fail_exp_o = ff_exp_q;
  assign first_fail_act_o = ff_act_q;

endmodule
